// File: rtl/soc_system_pio_pkg.sv
// +--------------------------------------------------------------------------+
// | soc_system_pio_pkg : shared register map and edge-type encodings for PIOs |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package soc_system_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

endpackage

`default_nettype wire

// File: rtl/soc_system_in_capture_if.sv
// +--------------------------------------------------------------------------+
// | soc_system_in_capture_if : Avalon-MM slave bus of the input capture PIO  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface soc_system_in_capture_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

endinterface

`default_nettype wire

// File: rtl/soc_system_in_debounce.sv
// +--------------------------------------------------------------------------+
// | soc_system_in_debounce : two-flop synchroniser plus stability counter    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module soc_system_in_debounce
  import soc_system_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic filt
);

  localparam int               c_d        = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(c_d - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Any sample that agrees with filt restarts the count, so only an
  // unbroken run of c_d differing samples moves the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      filt <= 1'b0;
      cnt  <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == filt) begin
        cnt <= '0;
      end else if (cnt == c_cnt_last) begin
        filt <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/soc_system_in_capture.sv
// +--------------------------------------------------------------------------+
// | soc_system_in_capture : debounced input PIO with edge capture and irq    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module soc_system_in_capture
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_TYPE       = 2,
  parameter int CNT_W           = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        in_port,
  soc_system_in_capture_if.slave  bus
);

  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] filt_d;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] cap_kept;
  logic [WIDTH-1:0] cap_next;
  logic [WIDTH-1:0] mask_next;
  logic [31:0]      rd_mux;
  logic             wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    soc_system_in_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .din   (in_port[i]),
      .filt  (filt[i])
    );
  end

  always_comb begin
    wr_en = bus.chipselect & ~bus.write_n;

    if (EDGE_TYPE == int'(EDGE_RISE))      evt = filt & ~filt_d;
    else if (EDGE_TYPE == int'(EDGE_FALL)) evt = ~filt & filt_d;
    else                                   evt = filt ^ filt_d;

    clr       = (wr_en && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;
    cap_kept  = edge_capture & ~clr;
    cap_next  = cap_kept | evt;
    mask_next = (wr_en && bus.address == ADDR_MASK) ? bus.writedata[WIDTH-1:0] : irq_mask;

    case (bus.address)
      ADDR_DATA: rd_mux = 32'(filt);
      ADDR_MASK: rd_mux = 32'(irq_mask);
      ADDR_EDGE: rd_mux = 32'(edge_capture);
      default:   rd_mux = 32'd0;
    endcase
  end

  // irq follows the registered capture (new events land one edge later),
  // but reacts on the same edge to a clear or an unmask write.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_d       <= '0;
      edge_capture <= '0;
      irq_mask     <= '0;
      bus.irq      <= 1'b0;
      bus.readdata <= 32'd0;
    end else begin
      filt_d       <= filt;
      edge_capture <= cap_next;
      irq_mask     <= mask_next;
      bus.irq      <= |(cap_kept & mask_next);
      bus.readdata <= bus.chipselect ? rd_mux : 32'd0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_soc_system_in_capture.sv
// +--------------------------------------------------------------------------+
// | tb_soc_system_in_capture : directed bench, one DUT at D=4 and one at D=1  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_soc_system_in_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] inp4;
  logic [7:0] inp1;
  int         n_cmp = 0;
  int         n_err = 0;

  soc_system_in_capture_if bus4 ();
  soc_system_in_capture_if bus1 ();

  always #5 clk = ~clk;

  soc_system_in_capture #(
    .WIDTH (8), .DEBOUNCE_CYCLES (4), .EDGE_TYPE (2), .CNT_W (16)
  ) dut4 (
    .clk (clk), .reset (reset), .in_port (inp4), .bus (bus4.slave)
  );

  soc_system_in_capture #(
    .WIDTH (8), .DEBOUNCE_CYCLES (1), .EDGE_TYPE (2), .CNT_W (16)
  ) dut1 (
    .clk (clk), .reset (reset), .in_port (inp1), .bus (bus1.slave)
  );

  task automatic bus_idle();
    bus4.chipselect = 1'b0; bus4.write_n = 1'b1; bus4.address = 2'd0; bus4.writedata = 32'd0;
    bus1.chipselect = 1'b0; bus1.write_n = 1'b1; bus1.address = 2'd0; bus1.writedata = 32'd0;
  endtask

  task automatic wr(input int sel, input logic [1:0] a, input logic [31:0] d);
    if (sel == 4) begin
      bus4.chipselect = 1'b1; bus4.write_n = 1'b0; bus4.address = a; bus4.writedata = d;
    end else begin
      bus1.chipselect = 1'b1; bus1.write_n = 1'b0; bus1.address = a; bus1.writedata = d;
    end
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic rd(input int sel, input logic [1:0] a, output logic [31:0] d);
    if (sel == 4) begin
      bus4.chipselect = 1'b1; bus4.write_n = 1'b1; bus4.address = a;
    end else begin
      bus1.chipselect = 1'b1; bus1.write_n = 1'b1; bus1.address = a;
    end
    @(posedge clk); #1;
    d = (sel == 4) ? bus4.readdata : bus1.readdata;
    bus_idle();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; inp4 = 8'h00; inp1 = 8'h00; bus_idle();
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (bus4.readdata !== 32'd0) begin n_err++; $display("FAIL reset_readdata actual=%h required=%h", bus4.readdata, 32'd0); end
    n_cmp++; if (bus4.irq !== 1'b0) begin n_err++; $display("FAIL reset_irq actual=%b required=0", bus4.irq); end
    reset = 1'b0;
    rd(4, 2'd0, d); n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_data actual=%h required=0", d); end
    rd(4, 2'd2, d); n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_mask actual=%h required=0", d); end
    rd(4, 2'd3, d); n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_edge actual=%h required=0", d); end
    inp4 = 8'hA5;
    repeat (10) @(posedge clk); #1;
    rd(4, 2'd0, d); n_cmp++; if (d !== 32'h000000A5) begin n_err++; $display("FAIL data_a5 actual=%h required=%h", d, 32'hA5); end
    rd(4, 2'd3, d); n_cmp++; if (d !== 32'h000000A5) begin n_err++; $display("FAIL edge_a5 actual=%h required=%h", d, 32'hA5); end
    rd(4, 2'd1, d); n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL rsvd actual=%h required=0", d); end
  endtask

  task automatic test_debounce();
    logic [31:0] d;
    inp4 = 8'h00;
    repeat (10) @(posedge clk); #1;
    wr(4, 2'd3, 32'hFF);
    inp4 = 8'h01;
    repeat (3) @(posedge clk); #1;
    inp4 = 8'h00;
    repeat (8) @(posedge clk); #1;
    rd(4, 2'd0, d); n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL glitch_data actual=%h required=0", d); end
    rd(4, 2'd3, d); n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL glitch_edge actual=%h required=0", d); end
    n_cmp++; if (bus4.irq !== 1'b0) begin n_err++; $display("FAIL glitch_irq actual=%b required=0", bus4.irq); end
    inp4 = 8'h01;
    repeat (4) @(posedge clk); #1;
    inp4 = 8'h00;
    repeat (12) @(posedge clk); #1;
    rd(4, 2'd3, d); n_cmp++; if (d !== 32'h01) begin n_err++; $display("FAIL hold4_edge actual=%h required=%h", d, 32'h01); end
  endtask

  task automatic test_latency();
    logic [31:0] d;
    wr(1, 2'd2, 32'h01);
    inp1 = 8'h01;
    for (int i = 0; i <= 4; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bus1.irq !== (i == 4)) begin
        n_err++; $display("FAIL latency_irq_k%0d actual=%b required=%b", i, bus1.irq, (i == 4));
      end
    end
    wr(1, 2'd3, 32'h01);
    n_cmp++; if (bus1.irq !== 1'b0) begin n_err++; $display("FAIL clear_irq actual=%b required=0", bus1.irq); end
    rd(1, 2'd3, d); n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL clear_edge actual=%h required=0", d); end
  endtask

  task automatic test_mask();
    logic [31:0] d;
    wr(1, 2'd2, 32'h00);
    inp1 = 8'h02;
    repeat (6) @(posedge clk); #1;
    n_cmp++; if (bus1.irq !== 1'b0) begin n_err++; $display("FAIL masked_irq actual=%b required=0", bus1.irq); end
    rd(1, 2'd3, d); n_cmp++; if (d !== 32'h03) begin n_err++; $display("FAIL masked_edge actual=%h required=%h", d, 32'h03); end
    wr(1, 2'd2, 32'h02);
    n_cmp++; if (bus1.irq !== 1'b1) begin n_err++; $display("FAIL unmask_irq actual=%b required=1", bus1.irq); end
    rd(1, 2'd2, d); n_cmp++; if (d !== 32'h02) begin n_err++; $display("FAIL mask_rb actual=%h required=%h", d, 32'h02); end
    wr(1, 2'd3, 32'h02);
    n_cmp++; if (bus1.irq !== 1'b0) begin n_err++; $display("FAIL w1c_irq actual=%b required=0", bus1.irq); end
    rd(1, 2'd3, d); n_cmp++; if (d !== 32'h01) begin n_err++; $display("FAIL w1c_edge actual=%h required=%h", d, 32'h01); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    wr(1, 2'd3, 32'h03);
    inp1 = 8'h00;
    repeat (6) @(posedge clk); #1;
    inp1 = 8'h02;
    repeat (3) @(posedge clk); #1;
    bus1.chipselect = 1'b1; bus1.write_n = 1'b0; bus1.address = 2'd3; bus1.writedata = 32'h02;
    @(posedge clk); #1;
    n_cmp++; if (bus1.readdata !== 32'h02) begin n_err++; $display("FAIL coinc_read actual=%h required=%h", bus1.readdata, 32'h02); end
    n_cmp++; if (bus1.irq !== 1'b0) begin n_err++; $display("FAIL coinc_irq actual=%b required=0", bus1.irq); end
    bus_idle();
    rd(1, 2'd3, d); n_cmp++; if (d !== 32'h02) begin n_err++; $display("FAIL coinc_edge actual=%h required=%h", d, 32'h02); end
    n_cmp++; if (bus1.irq !== 1'b1) begin n_err++; $display("FAIL coinc_irq_after actual=%b required=1", bus1.irq); end
  endtask

  task automatic test_reset_mid_debounce();
    logic [31:0] exp;
    inp4 = 8'hFF;
    repeat (4) @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus4.chipselect = 1'b1; bus4.write_n = 1'b1; bus4.address = 2'd0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      exp = (i == 7) ? 32'hFF : 32'h00;
      n_cmp++;
      if (bus4.readdata !== exp) begin
        n_err++; $display("FAIL rstmid_data_e%0d actual=%h required=%h", i, bus4.readdata, exp);
      end
      n_cmp++;
      if (bus4.irq !== 1'b0) begin
        n_err++; $display("FAIL rstmid_irq_e%0d actual=%b required=0", i, bus4.irq);
      end
    end
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_latency();
    test_mask();
    test_back_to_back();
    test_reset_mid_debounce();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
